oled_spi_ctrl: RTL

OLED_SPI_CTRL -- requirements
Module: oled_spi_ctrl

---
 rtl/oled_pkg.sv | 26 ++
 rtl/oled_byte_fifo.sv | 56 +++++
 rtl/oled_spi_ctrl.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/oled_pkg.sv
// Shared types and default parameter values for the Zedboard OLED SPI controller.
package oled_pkg;

  localparam int DEF_CLK_DIV    = 4;
  localparam int DEF_FIFO_DEPTH = 16;
  localparam int DEF_PWR_DLY    = 100000;
  localparam int DEF_RES_DLY    = 1000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_BIT_LO,
    S_BIT_HI,
    S_GAP
  } shift_state_e;

  typedef enum logic [2:0] {
    P_OFF,
    P_VDD_ON,
    P_RES_LO,
    P_RES_HI,
    P_VBAT_ON,
    P_READY
  } pwr_state_e;

endpackage

// File: rtl/oled_byte_fifo.sv
// Synchronous FIFO with a registered head word (rd_data) that is valid whenever
// the FIFO is non-empty, plus an occupancy count.
module oled_byte_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 9,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic [LW-1:0]    level,
  output logic             empty,
  output logic             full
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    rd_next;
  logic             push_ok;
  logic             pop_ok;

  assign empty   = (level == '0);
  assign full    = (level == LW'(DEPTH));
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rd_next = rd_ptr + 1'b1;

  always_ff @(posedge clock) begin
    if (push_ok) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
      rd_data <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_next;
      level <= level + LW'(push_ok) - LW'(pop_ok);
      // Head register: take the incoming word when it becomes the oldest entry,
      // otherwise advance to the next stored word on a pop.
      if (push_ok && (empty || (pop_ok && level == LW'(1))))
        rd_data <= wr_data;
      else if (pop_ok && level > LW'(1))
        rd_data <= mem[rd_next];
    end
  end

endmodule

// File: rtl/oled_spi_ctrl.sv
// Byte-FIFO fed SPI (mode 3, MSB first) driver for the Zedboard OLED panel.
// Define OLED_PWR_SEQ_EN to enable the VDD/RES/VBAT power-up sequencer.
module oled_spi_ctrl
  import oled_pkg::*;
#(
  parameter int CLK_DIV    = DEF_CLK_DIV,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int PWR_DLY    = DEF_PWR_DLY,
  parameter int RES_DLY    = DEF_RES_DLY
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [7:0]                    in_data,
  input  logic                          in_dc,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          pwr_done,
  output logic                          oled_sclk,
  output logic                          oled_sdin,
  output logic                          oled_dc,
  output logic                          oled_res_n,
  output logic                          oled_vdd_n,
  output logic                          oled_vbat_n,
  output logic [2:0]                    dbg_shift_state,
  output logic [2:0]                    dbg_pwr_state
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  shift_state_e state;
  logic [DW-1:0] div_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic [8:0]    head;
  logic          fifo_empty;
  logic          fifo_full;
  logic          pop;

  // Handshake: a byte transfers on a rising edge where in_valid && in_ready;
  // in_ready never depends on in_valid, and in_data/in_dc only matter then.
  assign in_ready        = pwr_done && !fifo_full;
  assign pop             = (state == S_LOAD);
  assign busy            = (state != S_IDLE) || !fifo_empty;
  assign dbg_shift_state = state;

  oled_byte_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(9)) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push    (in_valid && in_ready),
    .wr_data ({in_dc, in_data}),
    .pop     (pop),
    .rd_data (head),
    .level   (fifo_level),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

  // SDIN/DC only move together with an SCLK fall, so they are stable at every rise.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= S_IDLE;
      div_cnt   <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      oled_sclk <= 1'b1;
      oled_sdin <= 1'b0;
      oled_dc   <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: if (!fifo_empty) state <= S_LOAD;
        S_LOAD: begin
          shreg     <= head[7:0];
          oled_sdin <= head[7];
          oled_dc   <= head[8];
          oled_sclk <= 1'b0;
          bit_idx   <= 3'd7;
          div_cnt   <= '0;
          state     <= S_BIT_LO;
        end
        S_BIT_LO: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt   <= '0;
            oled_sclk <= 1'b1;
            state     <= S_BIT_HI;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        S_BIT_HI: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            if (bit_idx == 3'd0) begin
              state <= S_GAP;
            end else begin
              bit_idx   <= bit_idx - 1'b1;
              shreg     <= {shreg[6:0], 1'b0};
              oled_sdin <= shreg[6];
              oled_sclk <= 1'b0;
              state     <= S_BIT_LO;
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        S_GAP: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            state   <= fifo_empty ? S_IDLE : S_LOAD;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef OLED_PWR_SEQ_EN
  localparam logic [31:0] PWR_LAST = 32'(PWR_DLY - 1);
  localparam logic [31:0] RES_LAST = 32'(RES_DLY - 1);

  pwr_state_e  pwr_state;
  logic [31:0] pwr_cnt;

  assign dbg_pwr_state = pwr_state;

  always_ff @(posedge clock) begin
    if (reset) begin
      pwr_state   <= P_OFF;
      pwr_cnt     <= '0;
      pwr_done    <= 1'b0;
      oled_vdd_n  <= 1'b1;
      oled_res_n  <= 1'b1;
      oled_vbat_n <= 1'b1;
    end else begin
      pwr_cnt <= pwr_cnt + 1'b1;
      unique case (pwr_state)
        P_OFF: begin
          pwr_cnt    <= '0;
          oled_vdd_n <= 1'b0;
          pwr_state  <= P_VDD_ON;
        end
        P_VDD_ON: if (pwr_cnt == PWR_LAST) begin
          pwr_cnt    <= '0;
          oled_res_n <= 1'b0;
          pwr_state  <= P_RES_LO;
        end
        P_RES_LO: if (pwr_cnt == RES_LAST) begin
          pwr_cnt    <= '0;
          oled_res_n <= 1'b1;
          pwr_state  <= P_RES_HI;
        end
        P_RES_HI: if (pwr_cnt == RES_LAST) begin
          pwr_cnt     <= '0;
          oled_vbat_n <= 1'b0;
          pwr_state   <= P_VBAT_ON;
        end
        P_VBAT_ON: if (pwr_cnt == PWR_LAST) begin
          pwr_cnt   <= '0;
          pwr_done  <= 1'b1;
          pwr_state <= P_READY;
        end
        P_READY: pwr_cnt <= '0;
        default: pwr_state <= P_OFF;
      endcase
    end
  end
`else
  // Rails are treated as always on; they only read inactive while reset is held.
  assign dbg_pwr_state = pwr_done ? P_READY : P_OFF;

  always_ff @(posedge clock) begin
    if (reset) begin
      pwr_done    <= 1'b0;
      oled_vdd_n  <= 1'b1;
      oled_res_n  <= 1'b1;
      oled_vbat_n <= 1'b1;
    end else begin
      pwr_done    <= 1'b1;
      oled_vdd_n  <= 1'b0;
      oled_res_n  <= 1'b1;
      oled_vbat_n <= 1'b0;
    end
  end
`endif

endmodule
